line_loader: RTL and testbench
==============================

# line_loader

Upstream feeder for the lane-rotation controller. Receives the input state as a serial bit stream under a valid/ready handshake, packs each 25-bit line, and writes it into the shared line memory at consecutive addresses. After the last line it pulses `start` to the rotation controller, then holds off further input until that controller reports completion.

## Interface

Parameters:
- `LINE_W`, 25: bits per line; matches the rotation controller's `memsize`.
- `DEPTH`, 64: lines per frame.
- `ADDR_W`, 6: memory address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  source has a bit on `in_bit`.
- `in_bit`  in  1  serial data bit.
- `in_ready`  out  1  loader accepts a bit this cycle.
- `mem_we`  out  1  line-memory write strobe.
- `mem_addr`  out  ADDR_W  line-memory write address.
- `mem_wdata`  out  LINE_W  packed line.
- `start`  out  1  one-cycle pulse to the rotation controller.
- `core_done`  in  1  rotation controller has finished (its Ready state).
- `busy`  out  1  high in every state except IDLE.
- `frame_cnt`  out  8  number of frames loaded since reset; wraps at 255 -> 0.

## Operation

- States: IDLE, SHIFT, WRITE, KICK, WAIT.
- IDLE: `in_ready`=0. Moves to SHIFT when `in_valid`=1. The bit present on that cycle is not consumed.
- SHIFT: `in_ready`=1. On each accepted bit (`in_valid`&`in_ready`), the shift register updates as shreg <= {in_bit, shreg[LINE_W-1:1]}, and the bit counter increments. After LINE_W accepted bits, the first-received bit sits in bit 0. Acceptance of the LINE_W-th bit moves to WRITE.
- WRITE: `mem_we`=1, `mem_addr`=line counter, `mem_wdata`=shreg, all for exactly one cycle. The bit counter clears.
  - If line counter = DEPTH-1: line counter clears and the state moves to KICK.
  - Otherwise: line counter increments and the state returns to SHIFT.
- KICK: `start`=1 for one cycle; `frame_cnt` increments; next state is WAIT.
- WAIT: `in_ready`=0. Moves to IDLE on the first cycle `core_done`=1. A `core_done` that arrives in any other state is ignored.
- Gaps in `in_valid` during SHIFT stall the loader with no loss of bits.
- `mem_addr` and `mem_wdata` are registered. They hold their last values outside WRITE.

## Timing

- Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `start`=0, `busy`=0, `frame_cnt`=0. State is IDLE; counters and shreg are 0.
- Reset asserted mid-frame aborts the frame immediately:
  - no further `mem_we`;
  - the next frame after reset release starts again at address 0.
- Latency:
  - last bit of a line accepted at edge N -> `mem_we` high in cycle N+1;
  - last line written in cycle M -> `start` high in cycle M+1;
  - `core_done` seen in WAIT at edge K -> IDLE from K+1.
- Minimum frame time with continuous `in_valid`: 1 + DEPTH*(LINE_W+1) + 1 cycles from leaving IDLE to `start`.
- `in_ready` is a registered function of state only. It never depends combinationally on `in_valid`.

## Configuration

- `LINE_LOADER_PARITY_EN` defined:
  - each line is followed by one extra serial bit, even parity over the LINE_W data bits, accepted in SHIFT before WRITE;
  - on a mismatch, the line is still written and output `parity_err` (1 bit, reset 0) sets sticky until `rst`;
  - the bit counter runs to LINE_W+1.
- Macro undefined:
  - no parity bit is expected; `parity_err` is absent from the port list;
  - the bit counter runs to LINE_W.

## Test plan

- Reset then 64 lines, continuous `in_valid`, line i = i (LSB first) -> 64 writes, addr i / data i in order; one `start` pulse one cycle after addr 63; `frame_cnt`=1.
- Line 0 = 25'h1555555 fed with `in_valid` toggling every cycle -> single write, addr 0, data 25'h1555555, no extra or dropped bits.
- In WAIT, hold `in_valid`=1 for 20 cycles, then `core_done`=1 -> `in_ready`=0 throughout WAIT; IDLE the next cycle; the next frame starts at addr 0.
- Assert `rst` after 10 bits of line 5 -> all outputs return to reset values immediately; the next frame writes addr 0 first; no write to addr 5 from the aborted line.
- `core_done` pulsed during SHIFT -> ignored; after frame completion, WAIT persists until a new `core_done`.
- With `LINE_LOADER_PARITY_EN`: line 3 sent with a wrong parity bit -> line still written, `parity_err`=1 from the following cycle, stays 1 through subsequent frames until `rst`.

Source files
------------

// File: rtl/line_loader.sv
// line_loader: packs a serial bit stream into LINE_W-bit lines, writes DEPTH lines to memory, then kicks the rotation core.
// Optional LINE_LOADER_PARITY_EN: an even-parity bit follows each line; a mismatch sets sticky parity_err.
module line_loader #(
  parameter int LINE_W = 25,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  output logic              start,
  input  logic              core_done,
  output logic              busy,
  output logic [7:0]        frame_cnt
`ifdef LINE_LOADER_PARITY_EN
  ,
  output logic              parity_err
`endif
);
`ifdef LINE_LOADER_PARITY_EN
  localparam int NBITS = LINE_W + 1;
`else
  localparam int NBITS = LINE_W;
`endif
  localparam int CW = $clog2(NBITS + 1);
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_WRITE, S_KICK, S_WAIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] bit_q, bit_d;
  logic [ADDR_W-1:0] line_q, line_d, addr_q, addr_d;
  logic [LINE_W-1:0] shreg_q, shreg_d, wdata_q, wdata_d;
  logic [7:0] frame_q, frame_d;
  logic in_ready_q, mem_we_q, start_q, busy_q, acc;
`ifdef LINE_LOADER_PARITY_EN
  logic perr_q, perr_d;
  assign parity_err = perr_q;
`endif
  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign start     = start_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_q;
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    line_d  = line_q;
    shreg_d = shreg_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    frame_d = frame_q;
`ifdef LINE_LOADER_PARITY_EN
    perr_d  = perr_q;
`endif
    acc = in_valid & in_ready_q;
    case (state_q)
      S_IDLE:  state_d = in_valid ? S_SHIFT : S_IDLE;
      S_SHIFT: if (acc) begin
        bit_d = bit_q + CW'(1);
        if (bit_q < CW'(LINE_W)) shreg_d = {in_bit, shreg_q[LINE_W-1:1]};
`ifdef LINE_LOADER_PARITY_EN
        else perr_d = perr_q | (in_bit ^ (^shreg_q));
`endif
        // capture address and data on entry so both are registered during the write cycle
        if (bit_q == CW'(NBITS - 1)) begin
          state_d = S_WRITE;
          addr_d  = line_q;
          wdata_d = shreg_d;
        end
      end
      S_WRITE: begin
        bit_d   = '0;
        state_d = (line_q == ADDR_W'(DEPTH - 1)) ? S_KICK : S_SHIFT;
        line_d  = (line_q == ADDR_W'(DEPTH - 1)) ? '0 : line_q + ADDR_W'(1);
      end
      S_KICK: begin
        frame_d = frame_q + 8'd1;
        state_d = S_WAIT;
      end
      S_WAIT:  state_d = core_done ? S_IDLE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= S_IDLE;
      bit_q      <= '0;
      line_q     <= '0;
      shreg_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      frame_q    <= '0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef LINE_LOADER_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      line_q     <= line_d;
      shreg_q    <= shreg_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      frame_q    <= frame_d;
      in_ready_q <= state_d == S_SHIFT;
      mem_we_q   <= state_d == S_WRITE;
      start_q    <= state_d == S_KICK;
      busy_q     <= state_d != S_IDLE;
`ifdef LINE_LOADER_PARITY_EN
      perr_q     <= perr_d;
`endif
    end
endmodule

// File: tb/tb_line_loader.sv
// tb_line_loader: randomized frames checked against a queue-based model of the written lines.
module tb_line_loader;
  localparam int LW = 25, DP = 64, AW = 6;
  logic clk = 0, rst = 1, in_valid = 0, in_bit = 0, core_done = 0;
  logic in_ready, mem_we, start, busy;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [7:0] frame_cnt;
`ifdef LINE_LOADER_PARITY_EN
  logic parity_err;
`endif
  int tests = 0, fails = 0, cyc = 0, start_n = 0, start_cyc = 0, bad_line = -1;
  bit stuck = 0;
  int wa[$], wc[$];
  logic [LW-1:0] wd[$];
  logic [LW-1:0] exp_lines [DP];

  line_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .start(start),
    .core_done(core_done), .busy(busy), .frame_cnt(frame_cnt)
`ifdef LINE_LOADER_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (!rst && mem_we) begin
      wa.push_back(int'(mem_addr));
      wd.push_back(mem_wdata);
      wc.push_back(cyc);
    end
    if (!rst && start) begin
      start_n++;
      start_cyc = cyc;
    end
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
    start_n = 0;
  endtask

  // offers one bit and returns at the negedge after the edge that accepted it
  task automatic push_bit(input logic b, input int gap);
    int n = 0;
    if (stuck) return;
    if (gap > 0) begin
      in_valid = 0;
      repeat (gap) @(negedge clk);
    end
    in_valid = 1;
    in_bit = b;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      stuck = 1;
      $display("FAIL push_bit timeout: in_ready=%b required 1", in_ready);
      return;
    end
    @(negedge clk);
  endtask

  // mode 0: continuous valid, 1: valid toggles, 2: random gaps
  task automatic send_line(input int idx, input int mode);
    for (int i = 0; i < LW; i++)
      push_bit(exp_lines[idx][i], mode == 1 ? 1 : mode == 2 ? int'($urandom_range(0, 3)) : 0);
`ifdef LINE_LOADER_PARITY_EN
    push_bit((^exp_lines[idx]) ^ (idx == bad_line), mode == 2 ? int'($urandom_range(0, 3)) : 0);
`endif
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if ({in_ready, mem_we, start, busy, mem_addr, mem_wdata, frame_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h required 0", {in_ready, mem_we, start, busy, mem_addr, mem_wdata, frame_cnt});
    end
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL idle_hold: busy=%b in_ready=%b required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_full_frame();
    for (int i = 0; i < DP; i++) exp_lines[i] = LW'(i);
    clear_log();
    for (int i = 0; i < DP; i++) begin
      core_done = (i == 10);
      send_line(i, 0);
    end
    core_done = 0;
    in_valid = 0;
    repeat (3) @(negedge clk);
    tests++;
    if (wa.size() != DP) begin
      fails++;
      $display("FAIL full_write_count: got %0d required %0d", wa.size(), DP);
    end
    for (int i = 0; i < DP && i < wa.size(); i++) begin
      tests++;
      if (wa[i] != i || wd[i] !== exp_lines[i]) begin
        fails++;
        $display("FAIL full_write[%0d]: got addr %0d data %h required addr %0d data %h", i, wa[i], wd[i], i, exp_lines[i]);
      end
    end
    tests++;
    if (start_n != 1 || wc.size() != DP || start_cyc != wc[wc.size() - 1] + 1) begin
      fails++;
      $display("FAIL full_start: got %0d pulses at cycle %0d required 1 pulse one cycle after last write", start_n, start_cyc);
    end
    tests++;
    if (frame_cnt !== 8'd1) begin
      fails++;
      $display("FAIL full_frame_cnt: got %0d required 1", frame_cnt);
    end
  endtask

  task automatic test_wait_hold();
    in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL wait_hold[%0d]: in_ready=%b busy=%b required 0 1", i, in_ready, busy);
      end
    end
    core_done = 1;
    @(negedge clk);
    core_done = 0;
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL wait_release: busy=%b in_ready=%b required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_gaps();
    exp_lines[0] = 25'h1555555;
    for (int i = 1; i < DP; i++) exp_lines[i] = LW'($urandom);
    clear_log();
    send_line(0, 1);
    #1;
    tests++;
    if (wa.size() != 1 || wa[0] != 0 || wd[0] !== 25'h1555555) begin
      fails++;
      $display("FAIL toggle_line0: got %0d writes first addr %0d data %h required 1 write addr 0 data 1555555",
               wa.size(), wa.size() > 0 ? wa[0] : -1, wd.size() > 0 ? wd[0] : '0);
    end
    for (int i = 1; i < DP; i++) send_line(i, 2);
    in_valid = 0;
    repeat (3) @(negedge clk);
    tests++;
    if (wa.size() != DP || start_n != 1 || frame_cnt !== 8'd2) begin
      fails++;
      $display("FAIL gaps_frame: got %0d writes %0d starts frame_cnt %0d required %0d 1 2", wa.size(), start_n, frame_cnt, DP);
    end
    for (int i = 0; i < DP && i < wa.size(); i++) begin
      tests++;
      if (wa[i] != i || wd[i] !== exp_lines[i]) begin
        fails++;
        $display("FAIL gaps_write[%0d]: got addr %0d data %h required addr %0d data %h", i, wa[i], wd[i], i, exp_lines[i]);
      end
    end
    core_done = 1;
    @(negedge clk);
    core_done = 0;
  endtask

  task automatic test_reset_abort();
    bit hit5 = 0;
    for (int i = 0; i < DP; i++) exp_lines[i] = LW'($urandom);
    clear_log();
    for (int i = 0; i < 5; i++) send_line(i, 2);
    for (int i = 0; i < 10; i++) push_bit(exp_lines[5][i], 0);
    #2 rst = 1;
    in_valid = 0;
    #1;
    tests++;
    if ({in_ready, mem_we, start, busy, mem_addr, mem_wdata, frame_cnt} !== '0) begin
      fails++;
      $display("FAIL abort_outputs: got %h required 0", {in_ready, mem_we, start, busy, mem_addr, mem_wdata, frame_cnt});
    end
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    foreach (wa[i]) if (wa[i] == 5) hit5 = 1;
    tests++;
    if (wa.size() != 5 || hit5) begin
      fails++;
      $display("FAIL abort_writes: got %0d writes addr5=%0d required 5 writes addr5=0", wa.size(), hit5);
    end
    for (int i = 0; i < DP; i++) exp_lines[i] = LW'($urandom);
    clear_log();
    for (int i = 0; i < DP; i++) send_line(i, 2);
    in_valid = 0;
    repeat (3) @(negedge clk);
    tests++;
    if (wa.size() != DP || frame_cnt !== 8'd1) begin
      fails++;
      $display("FAIL abort_refill: got %0d writes frame_cnt %0d required %0d 1", wa.size(), frame_cnt, DP);
    end
    for (int i = 0; i < DP && i < wa.size(); i++) begin
      tests++;
      if (wa[i] != i || wd[i] !== exp_lines[i]) begin
        fails++;
        $display("FAIL abort_write[%0d]: got addr %0d data %h required addr %0d data %h", i, wa[i], wd[i], i, exp_lines[i]);
      end
    end
    core_done = 1;
    @(negedge clk);
    core_done = 0;
  endtask

`ifdef LINE_LOADER_PARITY_EN
  task automatic test_parity();
    for (int i = 0; i < DP; i++) exp_lines[i] = LW'($urandom);
    bad_line = 3;
    clear_log();
    for (int i = 0; i < DP; i++) begin
      send_line(i, 0);
      if (i == 2 || i == 3) begin
        tests++;
        if (parity_err !== (i == 3)) begin
          fails++;
          $display("FAIL parity_after_line%0d: got %b required %b", i, parity_err, i == 3);
        end
      end
    end
    in_valid = 0;
    repeat (3) @(negedge clk);
    tests++;
    if (wa.size() != DP || wa[3] != 3 || wd[3] !== exp_lines[3]) begin
      fails++;
      $display("FAIL parity_line3_written: got %0d writes required %0d with line 3 intact", wa.size(), DP);
    end
    core_done = 1;
    @(negedge clk);
    core_done = 0;
    bad_line = -1;
    for (int i = 0; i < DP; i++) send_line(i, 2);
    in_valid = 0;
    repeat (3) @(negedge clk);
    tests++;
    if (parity_err !== 1'b1) begin
      fails++;
      $display("FAIL parity_sticky: got %b required 1", parity_err);
    end
    #2 rst = 1;
    #1;
    tests++;
    if (parity_err !== 1'b0) begin
      fails++;
      $display("FAIL parity_reset: got %b required 0", parity_err);
    end
    @(negedge clk);
    rst = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_wait_hold();
    test_gaps();
    test_reset_abort();
`ifdef LINE_LOADER_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
